// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM threshold bank: counter modes, count direction
// and the channel-index width helper.
package pwm_pkg;

   localparam int PWM_MODE_EDGE   = 0;
   localparam int PWM_MODE_CENTER = 1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // A one-channel bank still needs a 1-bit index port.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pwm_threshold_bank_if.sv
// Bus between a controller and the PWM threshold bank: duty writes, commit
// requests, run enable, the PWM outputs and the counter state for observation.
interface pwm_threshold_bank_if #(
   parameter int NUM_CH = 2,
   parameter int WIDTH  = 8
);
   import pwm_pkg::*;

   localparam int CH_W = clog2_min1(NUM_CH);

   // wr_en and commit are single-cycle strobes sampled at every rising edge;
   // there is no ready/backpressure, so every strobe is accepted in the cycle
   // it is presented. en is a level, not a strobe.
   logic              en;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [WIDTH-1:0]  wr_duty;
   logic              commit;

   logic [NUM_CH-1:0] PWM_sig;
   logic              period_start;
   logic              pending;
   logic [WIDTH-1:0]  cnt;
   dir_e              dir;

   modport master (
      output en, wr_en, wr_ch, wr_duty, commit,
      input  PWM_sig, period_start, pending, cnt, dir
   );

   modport slave (
      input  en, wr_en, wr_ch, wr_duty, commit,
      output PWM_sig, period_start, pending, cnt, dir
   );

endinterface

// File: rtl/pwm_counter.sv
// Shared period counter: edge-aligned wrap or centre-aligned up/down sweep,
// with the period-boundary flag and period-start strobe.
module pwm_counter
   import pwm_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int CENTER_ALIGNED = PWM_MODE_EDGE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output dir_e             dir,
   output logic             boundary,
   output logic             period_start
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   dir_e             dir_q, dir_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         dir_q <= DIR_UP;
      end else begin
         cnt_q <= cnt_d;
         dir_q <= dir_d;
      end
   end

   // Centre mode turns around at max and at 1 so neither endpoint repeats.
   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!en) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (CENTER_ALIGNED == PWM_MODE_EDGE) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (dir_q == DIR_UP) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q - CNT_ONE;
            dir_d = DIR_DOWN;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            dir_d = DIR_UP;
         end
      end
   end

   // Boundary is the last cycle of a period: the next count is 0 going up.
   always_comb begin
      boundary = 1'b0;
      if (en) begin
         if (CENTER_ALIGNED == PWM_MODE_EDGE) begin
            boundary = (cnt_q == CNT_MAX);
         end else begin
            boundary = (dir_q == DIR_DOWN) && (cnt_q == CNT_ONE);
         end
      end
   end

   assign period_start = en & ~rst & (cnt_q == '0) & (dir_q == DIR_UP);
   assign cnt          = cnt_q;
   assign dir          = dir_q;

endmodule

// File: rtl/pwm_threshold_bank.sv
// NUM_CH PWM outputs off one shared counter, with double-buffered duty values
// that switch together only at a period boundary (or at once while disabled).
module pwm_threshold_bank
   import pwm_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int WIDTH          = 8,
   parameter int CENTER_ALIGNED = PWM_MODE_EDGE
) (
   input  logic                 clk,
   input  logic                 rst,
   pwm_threshold_bank_if.slave  bus
);

   localparam int CH_W = clog2_min1(NUM_CH);

   logic [WIDTH-1:0]  cnt;
   dir_e              dir;
   logic              boundary;
   logic              period_start;

   logic [WIDTH-1:0]  shadow_q [NUM_CH];
   logic [WIDTH-1:0]  shadow_d [NUM_CH];
   logic [WIDTH-1:0]  active_q [NUM_CH];
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] pwm_q;
   logic              pending_q;
   logic              transfer;

   pwm_counter #(
      .WIDTH          (WIDTH),
      .CENTER_ALIGNED (CENTER_ALIGNED)
   ) u_counter (
      .clk          (clk),
      .rst          (rst),
      .en           (bus.en),
      .cnt          (cnt),
      .dir          (dir),
      .boundary     (boundary),
      .period_start (period_start)
   );

   // Out-of-range channel indices match no entry and are dropped.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         shadow_d[i] = shadow_q[i];
         if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
            shadow_d[i] = bus.wr_duty;
         end
      end
   end

   // Transfer uses shadow_d so a write landing in the transfer cycle is included.
   assign transfer = (boundary | ~bus.en) & (pending_q | bus.commit);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         pending_q <= 1'b0;
         pwm_q     <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_q[i] <= shadow_d[i];
            if (transfer) begin
               active_q[i] <= shadow_d[i];
            end
         end
         pending_q <= ~transfer & (pending_q | bus.commit);
         pwm_q     <= bus.en ? hit : '0;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
      assign hit[g] = (cnt < active_q[g]);
   end

   assign bus.PWM_sig      = pwm_q;
   assign bus.period_start = period_start;
   assign bus.pending      = pending_q;
   assign bus.cnt          = cnt;
   assign bus.dir          = dir;

endmodule

// File: tb/tb_pwm_threshold_bank.sv
// Bench for pwm_threshold_bank: an edge-aligned 8-bit/2-channel instance and a
// centre-aligned 4-bit/3-channel instance checked against a period-phase model.
module tb_pwm_threshold_bank;

   localparam int NE = 2;
   localparam int WE = 8;
   localparam int NC = 3;
   localparam int WC = 4;

   typedef struct packed {
      logic [15:0]       phase;
      logic [2:0][15:0]  shadow;
      logic [2:0][15:0]  active;
      logic              pending;
      logic [2:0]        pwm;
   } model_t;

   logic   clk = 1'b0;
   logic   rst;
   model_t me, mc;
   int     n_checks = 0;
   int     n_pass   = 0;
   int     n_fail   = 0;
   int     hi [3];

   always #5 clk = ~clk;

   pwm_threshold_bank_if #(.NUM_CH(NE), .WIDTH(WE)) ife ();
   pwm_threshold_bank_if #(.NUM_CH(NC), .WIDTH(WC)) ifc ();

   pwm_threshold_bank #(.NUM_CH(NE), .WIDTH(WE), .CENTER_ALIGNED(0)) dut_e (
      .clk (clk),
      .rst (rst),
      .bus (ife)
   );

   pwm_threshold_bank #(.NUM_CH(NC), .WIDTH(WC), .CENTER_ALIGNED(1)) dut_c (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // Count value at a given position in the period.
   function automatic int cnt_of(input int ph, input int w, input bit center);
      int mx;
      mx = (1 << w) - 1;
      if (center && ph > mx) return 2 * mx - ph;
      return ph;
   endfunction

   // One clock edge of the bank, described by position within the period.
   function automatic model_t model_step(input model_t m, input int n, input int w,
                                         input bit center, input bit rst_i, input bit en_i,
                                         input bit wr_en_i, input int wr_ch_i,
                                         input int wr_duty_i, input bit commit_i);
      model_t r;
      int     mx, per, c;
      r   = m;
      mx  = (1 << w) - 1;
      per = center ? 2 * mx : mx + 1;
      if (rst_i) begin
         r = '0;
         return r;
      end
      c = cnt_of(int'(m.phase), w, center);
      for (int i = 0; i < 3; i++) r.pwm[i] = en_i && (i < n) && (c < int'(m.active[i]));
      if (wr_en_i && wr_ch_i < n) r.shadow[wr_ch_i] = wr_duty_i[15:0];
      if ((!en_i || int'(m.phase) == per - 1) && (m.pending || commit_i)) begin
         r.active  = r.shadow;
         r.pending = 1'b0;
      end else begin
         r.pending = m.pending | commit_i;
      end
      r.phase = en_i ? 16'((int'(m.phase) + 1) % per) : 16'd0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pwm_e",  32'(ife.PWM_sig), 32'(me.pwm[1:0]));
      chk("pend_e", 32'(ife.pending), 32'(me.pending));
      chk("ps_e",   32'(ife.period_start), 32'(ife.en && !rst && me.phase == 0));
      chk("cnt_e",  32'(ife.cnt), 32'(cnt_of(int'(me.phase), WE, 1'b0)));
      chk("pwm_c",  32'(ifc.PWM_sig), 32'(mc.pwm));
      chk("pend_c", 32'(ifc.pending), 32'(mc.pending));
      chk("ps_c",   32'(ifc.period_start), 32'(ifc.en && !rst && mc.phase == 0));
      chk("cnt_c",  32'(ifc.cnt), 32'(cnt_of(int'(mc.phase), WC, 1'b1)));
      chk("dir_c",  32'(ifc.dir), 32'(mc.phase > 16'd15));
   endtask

   task automatic tick();
      @(posedge clk);
      me = model_step(me, NE, WE, 1'b0, rst, ife.en, ife.wr_en, int'(ife.wr_ch),
                      int'(ife.wr_duty), ife.commit);
      mc = model_step(mc, NC, WC, 1'b1, rst, ifc.en, ifc.wr_en, int'(ifc.wr_ch),
                      int'(ifc.wr_duty), ifc.commit);
      #1;
      check_all();
   endtask

   task automatic count_high(input bit use_c, input int n);
      logic [2:0] v;
      for (int i = 0; i < 3; i++) hi[i] = 0;
      repeat (n) begin
         tick();
         v = use_c ? ifc.PWM_sig : {1'b0, ife.PWM_sig};
         for (int i = 0; i < 3; i++) hi[i] += int'(v[i]);
      end
   endtask

   task automatic wait_phase(input bit use_c, input int ph);
      for (int k = 0; k < 600; k++) begin
         if ((use_c ? int'(mc.phase) : int'(me.phase)) == ph) break;
         tick();
      end
      if (use_c) chk("wait_c", 32'(ifc.cnt), 32'(cnt_of(ph, WC, 1'b1)));
      else       chk("wait_e", 32'(ife.cnt), 32'(cnt_of(ph, WE, 1'b0)));
   endtask

   task automatic wait_commit(input bit use_c);
      for (int k = 0; k < 600; k++) begin
         if (!(use_c ? mc.pending : me.pending)) break;
         tick();
      end
      if (use_c) chk("commit_done_c", 32'(ifc.pending), 32'd0);
      else       chk("commit_done_e", 32'(ife.pending), 32'd0);
   endtask

   task automatic write_e(input int ch, input int duty);
      ife.wr_en = 1'b1; ife.wr_ch = 1'(ch); ife.wr_duty = 8'(duty);
      tick();
      ife.wr_en = 1'b0;
   endtask

   task automatic write_c(input int ch, input int duty);
      ifc.wr_en = 1'b1; ifc.wr_ch = 2'(ch); ifc.wr_duty = 4'(duty);
      tick();
      ifc.wr_en = 1'b0;
   endtask

   initial begin
      #5000000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      me = '0; mc = '0;
      rst = 1'b1;
      ife.en = 1'b0; ife.wr_en = 1'b0; ife.wr_ch = '0; ife.wr_duty = '0; ife.commit = 1'b0;
      ifc.en = 1'b0; ifc.wr_en = 1'b0; ifc.wr_ch = '0; ifc.wr_duty = '0; ifc.commit = 1'b0;
      tick();
      tick();
      chk("rst_pwm_e", 32'(ife.PWM_sig), 32'd0);
      chk("rst_ps_e",  32'(ife.period_start), 32'd0);
      rst = 1'b0;

      // Edge mode: 0x40 / 0xC0 after the first boundary.
      ife.en = 1'b1;
      repeat (3) tick();
      write_e(0, 8'h40);
      write_e(1, 8'hC0);
      ife.commit = 1'b1; tick(); ife.commit = 1'b0;
      chk("t1_pend", 32'(ife.pending), 32'd1);
      wait_commit(1'b0);
      repeat (2) tick();
      count_high(1'b0, 256);
      chk("t1_ch0_high", 32'(hi[0]), 32'd64);
      chk("t1_ch1_high", 32'(hi[1]), 32'd192);

      // Write plus commit mid-period waits for the wrap.
      wait_phase(1'b0, 8'h80);
      ife.wr_en = 1'b1; ife.wr_ch = 1'b0; ife.wr_duty = 8'h10; ife.commit = 1'b1;
      tick();
      ife.wr_en = 1'b0; ife.commit = 1'b0;
      chk("t2_pend", 32'(ife.pending), 32'd1);
      wait_commit(1'b0);
      repeat (2) tick();
      count_high(1'b0, 256);
      chk("t2_ch0_high", 32'(hi[0]), 32'd16);
      chk("t2_ch1_high", 32'(hi[1]), 32'd192);

      // Commit and write in the boundary cycle itself.
      wait_phase(1'b0, 255);
      ife.wr_en = 1'b1; ife.wr_ch = 1'b1; ife.wr_duty = 8'h20; ife.commit = 1'b1;
      tick();
      ife.wr_en = 1'b0; ife.commit = 1'b0;
      chk("t3_pend", 32'(ife.pending), 32'd0);
      repeat (2) tick();
      count_high(1'b0, 256);
      chk("t3_ch0_high", 32'(hi[0]), 32'd16);
      chk("t3_ch1_high", 32'(hi[1]), 32'd32);

      // Disable mid-period, commit while parked, re-enable.
      wait_phase(1'b0, 100);
      ife.en = 1'b0;
      tick();
      chk("t5_pwm_off", 32'(ife.PWM_sig), 32'd0);
      chk("t5_cnt_off", 32'(ife.cnt), 32'd0);
      ife.wr_en = 1'b1; ife.wr_ch = 1'b0; ife.wr_duty = 8'hA0; ife.commit = 1'b1;
      tick();
      ife.wr_en = 1'b0; ife.commit = 1'b0;
      chk("t5_pend", 32'(ife.pending), 32'd0);
      ife.en = 1'b1;
      #1;
      chk("t5_ps_en", 32'(ife.period_start), 32'd1);
      chk("t5_cnt_en", 32'(ife.cnt), 32'd0);
      repeat (2) tick();
      count_high(1'b0, 256);
      chk("t5_ch0_high", 32'(hi[0]), 32'd160);
      chk("t5_ch1_high", 32'(hi[1]), 32'd32);

      // Centre mode, 4 bits: duties 5, 0, 15 over a 30-cycle period.
      ifc.en = 1'b1;
      write_c(0, 5);
      write_c(1, 0);
      write_c(2, 15);
      ifc.commit = 1'b1; tick(); ifc.commit = 1'b0;
      wait_commit(1'b1);
      repeat (2) tick();
      count_high(1'b1, 30);
      chk("t4_ch0_high", 32'(hi[0]), 32'd9);
      chk("t4_ch1_high", 32'(hi[1]), 32'd0);
      chk("t4_ch2_high", 32'(hi[2]), 32'd29);

      // Reset while a commit is pending; out-of-range channel write.
      wait_phase(1'b1, 5);
      ifc.wr_en = 1'b1; ifc.wr_ch = 2'd1; ifc.wr_duty = 4'd3; ifc.commit = 1'b1;
      tick();
      ifc.wr_en = 1'b0; ifc.commit = 1'b0;
      chk("t6_pend", 32'(ifc.pending), 32'd1);
      rst = 1'b1;
      tick();
      chk("t6_rst_pend", 32'(ifc.pending), 32'd0);
      chk("t6_rst_pwm",  32'(ifc.PWM_sig), 32'd0);
      rst = 1'b0;
      ifc.en = 1'b0;
      ifc.wr_en = 1'b1; ifc.wr_ch = 2'd3; ifc.wr_duty = 4'd9; ifc.commit = 1'b1;
      tick();
      ifc.wr_en = 1'b0; ifc.commit = 1'b0;
      ifc.en = 1'b1;
      repeat (2) tick();
      count_high(1'b1, 30);
      chk("t6_ch0_high", 32'(hi[0]), 32'd0);
      chk("t6_ch1_high", 32'(hi[1]), 32'd0);
      chk("t6_ch2_high", 32'(hi[2]), 32'd0);

      // Random writes, commits, enable drops and occasional resets.
      for (int k = 0; k < 1500; k++) begin
         rst         = ($urandom_range(0, 599) == 0);
         ife.en      = ($urandom_range(0, 299) != 0);
         ife.wr_en   = ($urandom_range(0, 3) == 0);
         ife.wr_ch   = 1'($urandom_range(0, 1));
         ife.wr_duty = 8'($urandom_range(0, 255));
         ife.commit  = ($urandom_range(0, 40) == 0);
         ifc.en      = ($urandom_range(0, 49) != 0);
         ifc.wr_en   = ($urandom_range(0, 3) == 0);
         ifc.wr_ch   = 2'($urandom_range(0, 3));
         ifc.wr_duty = 4'($urandom_range(0, 15));
         ifc.commit  = ($urandom_range(0, 20) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
